// File: rtl/divide_pkg.sv
// Shared state encoding and default widths for the signed streaming divider.
package divide_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_FRAC_BITS  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_t;
endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, W cycles per division.
module div_core #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  div_reg;
    logic [W-1:0]  q_reg;
    logic [CW-1:0] count;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    // The dividend shifts out of q_reg's top while quotient bits shift in at the bottom.
    assign shifted = {rem, q_reg[W-1]};
    assign trial   = shifted - {1'b0, div_reg};

    always_ff @(posedge clock) begin
        if (reset) begin
            rem     <= '0;
            div_reg <= '0;
            q_reg   <= '0;
            count   <= '0;
            busy    <= 1'b0;
        end else if (start && !busy) begin
            rem     <= '0;
            div_reg <= divisor;
            q_reg   <= dividend;
            count   <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            rem   <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
            q_reg <= W'({q_reg, ~trial[W]});
            count <= count + CW'(1);
            if (count == CW'(W - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done     = busy && (count == CW'(W - 1));
    assign quotient = q_reg;
endmodule

// File: rtl/divide_stream.sv
// FIFO-to-FIFO signed fixed-point divider: pops A and B together, divides, pushes the quotient.
// Define DIVIDE_SATURATE_EN to clamp overflow and divide-by-zero instead of wrapping to 0.
module divide_stream
    import divide_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FRAC_BITS  = DEFAULT_FRAC_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  inA_rd_en,
    input  logic                  inA_empty,
    input  logic [DATA_WIDTH-1:0] inA_dout,
    output logic                  inB_rd_en,
    input  logic                  inB_empty,
    input  logic [DATA_WIDTH-1:0] inB_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din,
    output state_t                debug_state
);
    localparam int W = DATA_WIDTH + FRAC_BITS;
    localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t state, state_next;
    logic pop, push;
    logic core_busy, core_done;
    logic [W-1:0] core_q;
    logic a_neg, b_neg, b_zero;
`ifdef DIVIDE_SATURATE_EN
    logic a_zero;
`endif

    // Unsigned magnitudes; negating the most-negative value yields 2^(DATA_WIDTH-1), which is exact.
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    assign a_mag = inA_dout[DATA_WIDTH-1] ? -inA_dout : inA_dout;
    assign b_mag = inB_dout[DATA_WIDTH-1] ? -inB_dout : inB_dout;

    div_core #(.W(W)) u_core (
        .clock    (clock),
        .reset    (reset),
        .start    (pop),
        .dividend (W'(a_mag) << FRAC_BITS),
        .divisor  (W'(b_mag)),
        .busy     (core_busy),
        .done     (core_done),
        .quotient (core_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
`ifdef DIVIDE_SATURATE_EN
            a_zero <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (pop) begin
                a_neg  <= inA_dout[DATA_WIDTH-1];
                b_neg  <= inB_dout[DATA_WIDTH-1];
                b_zero <= (inB_dout == '0);
`ifdef DIVIDE_SATURATE_EN
                a_zero <= (inA_dout == '0);
`endif
            end
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (!inA_empty && !inB_empty && !core_busy) begin
                    pop        = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (core_done) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!out_full) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A zero magnitude keeps a positive sign so it can never become a nonzero negative.
    logic q_neg;
    logic [W-1:0] q_signed;
    logic [DATA_WIDTH-1:0] result;
    assign q_neg    = (a_neg ^ b_neg) && (core_q != '0);
    assign q_signed = q_neg ? -core_q : core_q;

    always_comb begin
        result = q_signed[DATA_WIDTH-1:0];
`ifdef DIVIDE_SATURATE_EN
        if (b_zero) begin
            result = a_zero ? '0 : (a_neg ? NEG_MIN : POS_MAX);
        end else if (!q_neg && core_q > W'(POS_MAX)) begin
            result = POS_MAX;
        end else if (q_neg && core_q > W'(NEG_MIN)) begin
            result = NEG_MIN;
        end
`else
        if (b_zero) begin
            result = '0;
        end
`endif
    end

    assign inA_rd_en   = pop && !reset;
    assign inB_rd_en   = pop && !reset;
    assign out_wr_en   = push && !reset;
    assign out_din     = (state == WRITE && !reset) ? result : '0;
    assign debug_state = state;
endmodule

// File: tb/tb_divide_stream.sv
// Scoreboard bench for divide_stream: two instances (FRAC_BITS 0 and 10) fed from queue FIFOs.
module tb_divide_stream;
  import divide_pkg::*;

  localparam int DW  = 32;
  localparam int FB0 = 0;
  localparam int FB1 = 10;
  localparam int W0  = DW + FB0;
  localparam int W1  = DW + FB1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic a0_rd, a0_empty, b0_rd, b0_empty, o0_wr, o0_full;
  logic [DW-1:0] a0_dout, b0_dout, o0_din;
  state_t st0;
  logic a1_rd, a1_empty, b1_rd, b1_empty, o1_wr, o1_full;
  logic [DW-1:0] a1_dout, b1_dout, o1_din;
  state_t st1;

  divide_stream #(.DATA_WIDTH(DW), .FRAC_BITS(FB0)) dut0 (
    .clock(clock), .reset(reset),
    .inA_rd_en(a0_rd), .inA_empty(a0_empty), .inA_dout(a0_dout),
    .inB_rd_en(b0_rd), .inB_empty(b0_empty), .inB_dout(b0_dout),
    .out_wr_en(o0_wr), .out_full(o0_full), .out_din(o0_din),
    .debug_state(st0)
  );

  divide_stream #(.DATA_WIDTH(DW), .FRAC_BITS(FB1)) dut1 (
    .clock(clock), .reset(reset),
    .inA_rd_en(a1_rd), .inA_empty(a1_empty), .inA_dout(a1_dout),
    .inB_rd_en(b1_rd), .inB_empty(b1_empty), .inB_dout(b1_dout),
    .out_wr_en(o1_wr), .out_full(o1_full), .out_din(o1_din),
    .debug_state(st1)
  );

  logic [DW-1:0] fa0[$], fb0[$], fa1[$], fb1[$];
  logic [DW-1:0] exp0_q[$], exp1_q[$];
  int pend0[$], pend1[$], pop_log0[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic pa0, pb0, pa1, pb1;
  logic stall0 = 1'b0;
  logic stall1 = 1'b0;
  logic [DW-1:0] dummy;

  always @(posedge clock) cyc++;

  // Reference: signed quotient of A*2^frac by B, truncated toward zero.
  function automatic logic [DW-1:0] model(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                          input int frac);
    longint n, q;
    n = longint'(a) * (longint'(1) << frac);
    if (b == 0) begin
`ifdef DIVIDE_SATURATE_EN
      if (a > 0) return 32'h7fffffff;
      if (a < 0) return 32'h80000000;
      return 32'h0;
`else
      return 32'h0;
`endif
    end
    q = n / longint'(b);
`ifdef DIVIDE_SATURATE_EN
    if (q > 64'sd2147483647) return 32'h7fffffff;
    if (q < -64'sd2147483648) return 32'h80000000;
`endif
    return q[DW-1:0];
  endfunction

  task automatic refresh();
    a0_empty = (fa0.size() == 0);
    b0_empty = (fb0.size() == 0);
    a0_dout  = a0_empty ? '0 : fa0[0];
    b0_dout  = b0_empty ? '0 : fb0[0];
    a1_empty = (fa1.size() == 0);
    b1_empty = (fb1.size() == 0);
    a1_dout  = a1_empty ? '0 : fa1[0];
    b1_dout  = b1_empty ? '0 : fb1[0];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_pair0(input logic [DW-1:0] a, input logic [DW-1:0] b);
    fa0.push_back(a);
    fb0.push_back(b);
    exp0_q.push_back(model(a, b, FB0));
    refresh();
  endtask

  task automatic push_pair1(input logic [DW-1:0] a, input logic [DW-1:0] b);
    fa1.push_back(a);
    fb1.push_back(b);
    exp1_q.push_back(model(a, b, FB1));
    refresh();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0 || fa0.size() != 0 || fb0.size() != 0 ||
            fa1.size() != 0 || fb1.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results still owed after %0d cycles, required 0",
               exp0_q.size() + exp1_q.size(), budget);
    end
    repeat (3) tick();
  endtask

  // FIFO models: pop the head one edge after the DUT asserted rd_en.
  always @(posedge clock) begin
    #1;
    if (pa0 === 1'b1 && fa0.size() > 0) dummy = fa0.pop_front();
    if (pb0 === 1'b1 && fb0.size() > 0) dummy = fb0.pop_front();
    if (pa1 === 1'b1 && fa1.size() > 0) dummy = fa1.pop_front();
    if (pb1 === 1'b1 && fb1.size() > 0) dummy = fb1.pop_front();
    refresh();
  end

  // Monitor: mid-cycle sampling of handshakes, scoreboard pops on every write.
  always @(negedge clock) begin
    pa0 = a0_rd; pb0 = b0_rd; pa1 = a1_rd; pb1 = b1_rd;
    if (reset) begin
      tests++;
      if (a0_rd !== 1'b0 || b0_rd !== 1'b0 || o0_wr !== 1'b0 || o0_din !== '0 ||
          a1_rd !== 1'b0 || b1_rd !== 1'b0 || o1_wr !== 1'b0 || o1_din !== '0) begin
        fails++;
        $display("FAIL reset_outputs: rd=%b%b%b%b wr=%b%b din=%h/%h, required all zero",
                 a0_rd, b0_rd, a1_rd, b1_rd, o0_wr, o1_wr, o0_din, o1_din);
      end
      pend0.delete(); pend1.delete();
      stall0 = 1'b0; stall1 = 1'b0;
    end else begin
      if (a0_rd || b0_rd) begin
        tests++;
        if (a0_rd !== b0_rd || a0_empty || b0_empty) begin
          fails++;
          $display("FAIL pop_pair0: rdA=%b rdB=%b emptyA=%b emptyB=%b, required paired pop of non-empty FIFOs",
                   a0_rd, b0_rd, a0_empty, b0_empty);
        end
        pend0.push_back(cyc);
        pop_log0.push_back(cyc);
      end
      if (a1_rd || b1_rd) begin
        tests++;
        if (a1_rd !== b1_rd || a1_empty || b1_empty) begin
          fails++;
          $display("FAIL pop_pair1: rdA=%b rdB=%b emptyA=%b emptyB=%b, required paired pop of non-empty FIFOs",
                   a1_rd, b1_rd, a1_empty, b1_empty);
        end
        pend1.push_back(cyc);
      end
      if (o0_full) stall0 = 1'b1;
      if (o1_full) stall1 = 1'b1;
      if (o0_wr) begin
        tests++;
        if (exp0_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write0: got %0d, required no write", $signed(o0_din));
        end else begin
          dummy = exp0_q.pop_front();
          if (o0_din !== dummy) begin
            fails++;
            $display("FAIL quotient0: got %0d, required %0d", $signed(o0_din), $signed(dummy));
          end
        end
        if (pend0.size() > 0) begin
          int pc;
          pc = pend0.pop_front();
          if (!stall0) begin
            tests++;
            if (cyc - pc != W0 + 1) begin
              fails++;
              $display("FAIL latency0: got %0d cycles, required %0d", cyc - pc, W0 + 1);
            end
          end
        end
        stall0 = 1'b0;
      end
      if (o1_wr) begin
        tests++;
        if (exp1_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write1: got %0d, required no write", $signed(o1_din));
        end else begin
          dummy = exp1_q.pop_front();
          if (o1_din !== dummy) begin
            fails++;
            $display("FAIL quotient1: got %0d, required %0d", $signed(o1_din), $signed(dummy));
          end
        end
        if (pend1.size() > 0) begin
          int pc;
          pc = pend1.pop_front();
          if (!stall1) begin
            tests++;
            if (cyc - pc != W1 + 1) begin
              fails++;
              $display("FAIL latency1: got %0d cycles, required %0d", cyc - pc, W1 + 1);
            end
          end
        end
        stall1 = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] corners[8];
    logic [DW-1:0] ra, rb, ev;
    int base, n;
    corners = '{32'h80000000, 32'h7fffffff, 32'hffffffff, 32'h1,
                32'h0, 32'h80000001, 32'h2, 32'hfffffffe};
    o0_full = 1'b0;
    o1_full = 1'b0;
    refresh();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tests++;
    if (o0_wr !== 1'b0 || o0_din !== '0 || a0_rd !== 1'b0 || st0 !== IDLE) begin
      fails++;
      $display("FAIL idle_after_reset: wr=%b din=%h rd=%b state=%0d, required 0/0/0/IDLE",
               o0_wr, o0_din, a0_rd, st0);
    end

    // Four queued pairs: checks values, in-order delivery and back-to-back throughput.
    pop_log0.delete();
    push_pair0(32'd100, 32'd7);
    push_pair0(-32'sd100, 32'd7);
    push_pair0(32'd100, -32'sd7);
    push_pair0(-32'sd7, 32'd2);
    wait_drain(400);
    tests++;
    if (pop_log0.size() != 4) begin
      fails++;
      $display("FAIL pop_count: got %0d pops, required 4", pop_log0.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        tests++;
        if (pop_log0[i] - pop_log0[i-1] != W0 + 2) begin
          fails++;
          $display("FAIL throughput: pop gap %0d, required %0d", pop_log0[i] - pop_log0[i-1], W0 + 2);
        end
      end
    end

    // Divide-by-zero, overflow and extreme operands.
    push_pair0(32'd5, 32'd0);
    push_pair0(32'h80000000, 32'hffffffff);
    push_pair0(-32'sd5, 32'd0);
    push_pair0(32'd0, 32'd0);
    push_pair0(32'h80000000, 32'd1);
    push_pair0(32'h7fffffff, 32'hffffffff);
    push_pair0(32'd0, 32'd5);
    push_pair0(32'd7, -32'sd100);
    wait_drain(800);

    // Dividend available without divisor: no pop of either side.
    base = pop_log0.size();
    fa0.push_back(32'd1234);
    refresh();
    repeat (12) tick();
    tests++;
    if (pop_log0.size() != base || fa0.size() != 1) begin
      fails++;
      $display("FAIL lone_dividend: pops=%0d fifoA=%0d, required 0 pops and 1 entry",
               pop_log0.size() - base, fa0.size());
    end
    fb0.push_back(32'd10);
    exp0_q.push_back(model(32'd1234, 32'd10, FB0));
    refresh();
    wait_drain(200);

    // Output back-pressure for 20 cycles in WRITE.
    o0_full = 1'b1;
    push_pair0(32'd1000, -32'sd3);
    ev = model(32'd1000, -32'sd3, FB0);
    n = 0;
    while (st0 !== WRITE && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (st0 !== WRITE) begin
      fails++;
      $display("FAIL reach_write: state %0d, required WRITE", st0);
    end
    push_pair0(32'd44, 32'd4);
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (o0_wr !== 1'b0 || o0_din !== ev || a0_rd !== 1'b0 || b0_rd !== 1'b0) begin
        fails++;
        $display("FAIL stall: wr=%b din=%0d rd=%b%b, required wr=0 din=%0d rd=00",
                 o0_wr, $signed(o0_din), a0_rd, b0_rd, $signed(ev));
      end
    end
    o0_full = 1'b0;
    wait_drain(200);

    // Fixed-point instance.
    push_pair1(32'd3, 32'd2);
    push_pair1(-32'sd1, 32'd3);
    push_pair1(32'h80000000, 32'd1);
    push_pair1(32'd7, 32'd0);
    for (int i = 0; i < 10; i++) begin
      push_pair1($urandom, $urandom_range(0, 1) ? $urandom : $urandom_range(1, 5000));
    end
    wait_drain(1000);

    // Reset during CALC discards the pair; the next pair is unaffected.
    base = pop_log0.size();
    fa0.push_back(32'd100);
    fb0.push_back(32'd7);
    refresh();
    n = 0;
    while (pop_log0.size() == base && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (pop_log0.size() == base) begin
      fails++;
      $display("FAIL reset_pair_pop: no pop seen, required one pop");
    end
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_pair0(32'd9, 32'd3);
    wait_drain(200);

    // Randomized pairs with intermittent back-pressure.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom_range(0, 400) - 200; rb = $urandom_range(0, 40) - 20; end
        2: begin ra = $urandom; rb = $urandom_range(0, 16) - 8; end
        3: begin ra = corners[$urandom_range(0, 7)]; rb = corners[$urandom_range(0, 7)]; end
        default: begin ra = $urandom; rb = 32'd0; end
      endcase
      o0_full = ($urandom_range(0, 3) == 0);
      push_pair0(ra, rb);
      repeat ($urandom_range(0, 40)) tick();
    end
    o0_full = 1'b0;
    wait_drain(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
